seg_stream_rx: RTL and testbench
================================

Name: seg_stream_rx

Overview:
- Receiver and decoder for the bit-serial 7-segment display stream produced by the clock core.
- The stream carries one segment bit plus a 3-bit segment index and a 3-bit digit index.
- The block rebuilds the 6 digit patterns, decodes them back to BCD, and presents a whole HH:MM:SS frame with a valid strobe.
- It sits on the display/monitor side and feeds the self-check and readback logic.

Parameters:
- STABLE_CYCLES, 4: clk cycles an index pair must hold unchanged before its bit is sampled (1..15).
- NUM_DIGITS, 6: digits per frame. Fixed at 6; other values are unsupported.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- seg_bit  in  1  serial segment level from the transmitter.
- seg_idx  in  3  segment index, 0..6.
- disp_idx  in  3  digit index, 0..5 (0 = seconds units).
- disp_type  in  1  polarity: 1 = active-low stream, 0 = active-high.
- digits  out  24  decoded frame; digit k at [4k+3:4k]; 0-9 digit, 4'hA blank, 4'hE invalid pattern.
- frame_valid  out  1  one-cycle pulse when digits updates.
- decode_err  out  1  valid with frame_valid; 1 if any digit in the frame decoded to 4'hE.
- seq_err  out  1  one-cycle pulse on an index sequence violation.
- locked  out  1  FSM is in RECV.

Behaviour:
- Reset (synchronous, active-high): digits=0, frame_valid=0, decode_err=0, seq_err=0, locked=0, FSM=SYNC. Synchronizers, stability counter, pattern buffers and expected index are cleared. A partial frame is discarded.
- Input sync: seg_bit, seg_idx, disp_idx and disp_type each pass through 2 flops. Downstream logic uses only the synced copies.
- Stability / sample event:
  - Pair P = {disp_idx, seg_idx}.
  - If P differs from its previous-cycle value: counter=0, armed=1.
  - Else if armed and counter==STABLE_CYCLES-1: one-cycle sample event, armed=0.
  - Else the counter increments and saturates.
  - Result: exactly one sample per index occupancy. Occupancies shorter than STABLE_CYCLES yield no sample.
  - Pin-to-sample latency = 2 + STABLE_CYCLES cycles.
- Out-of-range samples (seg_idx==7 or disp_idx>5) are ignored: no state change, no error.
- Captured bit: lit = disp_type ? ~seg_bit : seg_bit, using synced disp_type at the sample.
- FSM SYNC:
  - Sample with P==(0,0): store lit in pat[0], set expected=(0,1), go to RECV.
  - All other samples are ignored.
- FSM RECV, sample P==expected:
  - pat[seg_idx]=lit.
  - When seg_idx==6, decode pat into buf[disp_idx].
  - Expected advances: seg+1, or (disp+1, 0) after seg 6.
- Frame completion:
  - Occurs on the sample at P==(5,6).
  - Next cycle: digits=buf (including digit 5 just decoded), frame_valid=1, decode_err = OR of the invalid flags.
  - expected=(0,0); FSM stays in RECV.
- FSM RECV, sample P!=expected:
  - seq_err pulses for 1 cycle.
  - If P==(0,0): restart the frame (pat[0]=lit, expected=(0,1), stay in RECV).
  - Otherwise go to SYNC.
  - The buffer is discarded in both cases; digits holds its last value.
- Decode of lit pattern pat[6:0]:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 67→9.
  - 00→A (blank).
  - Anything else→E and sets that digit's invalid flag.
- disp_type may change between digits; each bit is normalized independently.
- Reset asserted mid-frame has priority over every event in that cycle.

Test Plan:
- Reset, then send 12:34:56 with disp_type=1, each index held 10 cycles -> one frame_valid, digits=24'h123456, decode_err=0, locked=1, seq_err never asserted.
- Same frame with disp_type=0 (bits inverted) -> digits=24'h123456. Two back-to-back frames -> two frame_valid pulses, 42 samples apart.
- Frame with digits 2..5 blank and seconds 07 -> digits=24'hAAAA07, decode_err=0.
- Jump from (2,3) to (2,5) mid-frame -> seq_err 1-cycle pulse, locked=0, digits unchanged, no frame_valid until a complete frame starting at (0,0) arrives.
- Digit 3 pattern 0x7E -> frame_valid with decode_err=1, digits[15:12]=4'hE, other digits correct.
- Index held STABLE_CYCLES-1 cycles then returned -> no sample, no seq_err. Assert rst at (3,2) -> all outputs 0, locked=0; next full frame 00:00:09 -> digits=24'h000009.

Source files
------------

// File: rtl/seg_stream_rx_if.sv
// rtl/seg_stream_rx_if.sv - serial 7-segment stream and decoded frame bundle
interface seg_stream_rx_if;
  logic        seg_bit;
  logic [2:0]  seg_idx;
  logic [2:0]  disp_idx;
  logic        disp_type;
  logic [23:0] digits;
  logic        frame_valid;
  logic        decode_err;
  logic        seq_err;
  logic        locked;

  modport master (
    output seg_bit, seg_idx, disp_idx, disp_type,
    input  digits, frame_valid, decode_err, seq_err, locked
  );

  modport slave (
    input  seg_bit, seg_idx, disp_idx, disp_type,
    output digits, frame_valid, decode_err, seq_err, locked
  );
endinterface

// File: rtl/seg_stream_rx.sv
// rtl/seg_stream_rx.sv - rebuilds and decodes the serial 7-segment stream into HH:MM:SS frames
module seg_stream_rx #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  seg_stream_rx_if.slave s_if
);

  localparam logic [3:0] CNT_LAST  = 4'(STABLE_CYCLES - 1);
  localparam logic [2:0] LAST_DISP = 3'(NUM_DIGITS - 1);

  typedef enum logic { SYNC, RECV } state_t;

  logic        r_bit_s1, r_bit_s2, r_type_s1, r_type_s2;
  logic [2:0]  r_seg_s1, r_seg_s2, r_disp_s1, r_disp_s2;
  logic [5:0]  r_pair_prev;
  logic [3:0]  r_cnt;
  logic        r_armed;
  state_t      r_state;
  logic [2:0]  r_exp_disp, r_exp_seg;
  logic [6:0]  r_pat;
  logic [23:0] r_buf;
  logic [5:0]  r_inv;
  logic [23:0] r_digits;
  logic        r_frame_valid, r_decode_err, r_seq_err;

  logic [5:0]  w_pair;
  logic        w_change, w_sample, w_in_range, w_take, w_lit, w_is_exp, w_is_origin;
  logic [4:0]  w_dec;
  logic [23:0] w_buf_next;
  logic [5:0]  w_inv_next;

  // Returns {invalid, value}; 4'hA is a blank digit.
  function automatic logic [4:0] decode7(input logic [6:0] p);
    case (p)
      7'h3F:   decode7 = {1'b0, 4'd0};
      7'h06:   decode7 = {1'b0, 4'd1};
      7'h5B:   decode7 = {1'b0, 4'd2};
      7'h4F:   decode7 = {1'b0, 4'd3};
      7'h66:   decode7 = {1'b0, 4'd4};
      7'h6D:   decode7 = {1'b0, 4'd5};
      7'h7D:   decode7 = {1'b0, 4'd6};
      7'h07:   decode7 = {1'b0, 4'd7};
      7'h7F:   decode7 = {1'b0, 4'd8};
      7'h67:   decode7 = {1'b0, 4'd9};
      7'h00:   decode7 = {1'b0, 4'hA};
      default: decode7 = {1'b1, 4'hE};
    endcase
  endfunction

  assign w_pair      = {r_disp_s2, r_seg_s2};
  assign w_change    = (w_pair != r_pair_prev);
  assign w_sample    = !w_change && r_armed && (r_cnt == CNT_LAST);
  assign w_in_range  = (r_seg_s2 != 3'd7) && (r_disp_s2 <= LAST_DISP);
  assign w_take      = w_sample && w_in_range;
  assign w_lit       = r_type_s2 ? ~r_bit_s2 : r_bit_s2;
  assign w_is_exp    = (r_disp_s2 == r_exp_disp) && (r_seg_s2 == r_exp_seg);
  assign w_is_origin = (w_pair == 6'd0);
  assign w_dec       = decode7({w_lit, r_pat[5:0]});

  always_comb begin
    w_buf_next = r_buf;
    w_inv_next = r_inv;
    for (int k = 0; k < 6; k++) begin
      if (r_disp_s2 == 3'(k)) begin
        w_buf_next[4*k +: 4] = w_dec[3:0];
        w_inv_next[k]        = w_dec[4];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_s1 <= 1'b0; r_bit_s2 <= 1'b0; r_type_s1 <= 1'b0; r_type_s2 <= 1'b0;
      r_seg_s1 <= 3'd0; r_seg_s2 <= 3'd0; r_disp_s1 <= 3'd0; r_disp_s2 <= 3'd0;
      r_pair_prev   <= 6'd0;
      r_cnt         <= 4'd0;
      r_armed       <= 1'b1;
      r_state       <= SYNC;
      r_exp_disp    <= 3'd0;
      r_exp_seg     <= 3'd0;
      r_pat         <= 7'd0;
      r_buf         <= 24'd0;
      r_inv         <= 6'd0;
      r_digits      <= 24'd0;
      r_frame_valid <= 1'b0;
      r_decode_err  <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      r_bit_s1  <= s_if.seg_bit;   r_bit_s2  <= r_bit_s1;
      r_type_s1 <= s_if.disp_type; r_type_s2 <= r_type_s1;
      r_seg_s1  <= s_if.seg_idx;   r_seg_s2  <= r_seg_s1;
      r_disp_s1 <= s_if.disp_idx;  r_disp_s2 <= r_disp_s1;

      r_frame_valid <= 1'b0;
      r_seq_err     <= 1'b0;
      r_pair_prev   <= w_pair;

      // One sample per occupancy: the armed flag drops once the bit is taken.
      if (w_change) begin
        r_cnt   <= 4'd0;
        r_armed <= 1'b1;
      end else if (w_sample) begin
        r_armed <= 1'b0;
      end else if (r_cnt != 4'hF) begin
        r_cnt <= r_cnt + 4'd1;
      end

      if (w_take) begin
        case (r_state)
          SYNC: begin
            if (w_is_origin) begin
              r_pat[0]   <= w_lit;
              r_exp_disp <= 3'd0;
              r_exp_seg  <= 3'd1;
              r_state    <= RECV;
            end
          end
          RECV: begin
            if (w_is_exp) begin
              r_pat[r_seg_s2] <= w_lit;
              if (r_seg_s2 == 3'd6) begin
                r_buf <= w_buf_next;
                r_inv <= w_inv_next;
                if (r_disp_s2 == LAST_DISP) begin
                  r_digits      <= w_buf_next;
                  r_frame_valid <= 1'b1;
                  r_decode_err  <= |w_inv_next;
                  r_exp_disp    <= 3'd0;
                  r_exp_seg     <= 3'd0;
                end else begin
                  r_exp_disp <= r_disp_s2 + 3'd1;
                  r_exp_seg  <= 3'd0;
                end
              end else begin
                r_exp_seg <= r_seg_s2 + 3'd1;
              end
            end else begin
              r_seq_err <= 1'b1;
              r_buf     <= 24'd0;
              r_inv     <= 6'd0;
              if (w_is_origin) begin
                r_pat[0]   <= w_lit;
                r_exp_disp <= 3'd0;
                r_exp_seg  <= 3'd1;
              end else begin
                r_state <= SYNC;
              end
            end
          end
          default: r_state <= SYNC;
        endcase
      end
    end
  end

  assign s_if.digits      = r_digits;
  assign s_if.frame_valid = r_frame_valid;
  assign s_if.decode_err  = r_decode_err;
  assign s_if.seq_err     = r_seq_err;
  assign s_if.locked      = (r_state == RECV);

endmodule

// File: tb/tb_seg_stream_rx.sv
// tb/tb_seg_stream_rx.sv - scoreboard bench for the serial 7-segment stream receiver
module tb_seg_stream_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_stream_rx_if u_if ();

  seg_stream_rx #(.STABLE_CYCLES(4), .NUM_DIGITS(6)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .s_if (u_if)
  );

  int checks = 0;
  int errors = 0;
  logic [24:0] sb_q[$];
  int seq_cnt = 0;
  int fv_cnt = 0;
  int cyc = 0;
  int last_fv = 0;
  int prev_fv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every frame_valid pops the oldest expected {decode_err, digits}.
  always @(negedge clk) begin
    logic [24:0] exp_v;
    if (!rst) begin
      if (u_if.seq_err) seq_cnt++;
      if (u_if.frame_valid) begin
        fv_cnt++;
        prev_fv = last_fv;
        last_fv = cyc;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame got digits=%h err=%b want no frame", u_if.digits, u_if.decode_err);
        end else begin
          exp_v = sb_q.pop_front();
          if ({u_if.decode_err, u_if.digits} !== exp_v) begin
            errors++;
            $display("FAIL frame got err=%b digits=%h want err=%b digits=%h",
                     u_if.decode_err, u_if.digits, exp_v[24], exp_v[23:0]);
          end
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 7'h3F;  4'd1: seg7 = 7'h06;  4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;  4'd4: seg7 = 7'h66;  4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;  4'd7: seg7 = 7'h07;  4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h67;  default: seg7 = 7'h00;
    endcase
  endfunction

  function automatic logic [41:0] mk_pats(input logic [23:0] bcd);
    logic [41:0] p;
    p = '0;
    for (int k = 0; k < 6; k++) p[7*k +: 7] = seg7(bcd[4*k +: 4]);
    return p;
  endfunction

  task automatic hold_sym(input logic [2:0] d, input logic [2:0] s, input logic b, input logic t, input int n);
    u_if.disp_idx  = d;
    u_if.seg_idx   = s;
    u_if.seg_bit   = b;
    u_if.disp_type = t;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hold_sym(3'd7, 3'd7, 1'b0, 1'b0, n);
  endtask

  task automatic send_frame(input logic [41:0] pats, input logic t, input int nsym, input int hold);
    logic lit;
    for (int i = 0; i < nsym; i++) begin
      lit = pats[i];
      hold_sym(3'(i / 7), 3'(i % 7), t ? ~lit : lit, t, hold);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    checks += 5;
    if (u_if.digits !== 24'd0) begin errors++; $display("FAIL reset_digits got %h want 000000", u_if.digits); end
    if (u_if.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", u_if.frame_valid); end
    if (u_if.decode_err !== 1'b0) begin errors++; $display("FAIL reset_derr got %b want 0", u_if.decode_err); end
    if (u_if.seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq got %b want 0", u_if.seq_err); end
    if (u_if.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", u_if.locked); end
  endtask

  task automatic test_basic_low();
    sb_q.push_back({1'b0, 24'h123456});
    send_frame(mk_pats(24'h123456), 1'b1, 42, 10);
    idle(4);
    wait_drain();
    checks += 3;
    if (sb_q.size() != 0) begin errors++; $display("FAIL basic_pending got %0d want 0", sb_q.size()); end
    if (u_if.locked !== 1'b1) begin errors++; $display("FAIL basic_locked got %b want 1", u_if.locked); end
    if (seq_cnt != 0) begin errors++; $display("FAIL basic_seq got %0d want 0", seq_cnt); end
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = fv_cnt;
    sb_q.push_back({1'b0, 24'h123456});
    sb_q.push_back({1'b0, 24'h123456});
    send_frame(mk_pats(24'h123456), 1'b0, 42, 10);
    send_frame(mk_pats(24'h123456), 1'b0, 42, 10);
    idle(4);
    wait_drain();
    checks += 3;
    if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d want 0", sb_q.size()); end
    if (fv_cnt - f0 != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", fv_cnt - f0); end
    if (last_fv - prev_fv != 420) begin errors++; $display("FAIL b2b_spacing got %0d want 420", last_fv - prev_fv); end
  endtask

  task automatic test_blank();
    sb_q.push_back({1'b0, 24'hAAAA07});
    send_frame(mk_pats(24'hAAAA07), 1'b1, 42, 10);
    idle(4);
    wait_drain();
    checks += 1;
    if (sb_q.size() != 0) begin errors++; $display("FAIL blank_pending got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_seq_jump();
    int s0, f0;
    s0 = seq_cnt;
    f0 = fv_cnt;
    send_frame(mk_pats(24'h123456), 1'b1, 2*7 + 4, 10);
    hold_sym(3'd2, 3'd5, 1'b0, 1'b1, 10);
    idle(4);
    checks += 4;
    if (seq_cnt - s0 != 1) begin errors++; $display("FAIL jump_seq_cycles got %0d want 1", seq_cnt - s0); end
    if (u_if.locked !== 1'b0) begin errors++; $display("FAIL jump_locked got %b want 0", u_if.locked); end
    if (u_if.digits !== 24'hAAAA07) begin errors++; $display("FAIL jump_digits got %h want aaaa07", u_if.digits); end
    if (fv_cnt != f0) begin errors++; $display("FAIL jump_fv got %0d want %0d", fv_cnt, f0); end
    sb_q.push_back({1'b0, 24'h123456});
    send_frame(mk_pats(24'h123456), 1'b1, 42, 10);
    idle(4);
    wait_drain();
    checks += 1;
    if (sb_q.size() != 0) begin errors++; $display("FAIL resync_pending got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_decode_err();
    logic [41:0] p;
    p = mk_pats(24'h123456);
    p[3*7 +: 7] = 7'h7E;
    sb_q.push_back({1'b1, 24'h12E456});
    send_frame(p, 1'b0, 42, 10);
    idle(4);
    wait_drain();
    checks += 1;
    if (sb_q.size() != 0) begin errors++; $display("FAIL derr_pending got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_glitch_recv();
    int s0;
    s0 = seq_cnt;
    hold_sym(3'd0, 3'd1, 1'b1, 1'b0, 3);
    idle(10);
    checks += 2;
    if (seq_cnt != s0) begin errors++; $display("FAIL glitch_seq got %0d want %0d", seq_cnt, s0); end
    if (u_if.locked !== 1'b1) begin errors++; $display("FAIL glitch_locked got %b want 1", u_if.locked); end
  endtask

  task automatic test_reset_midframe();
    send_frame(mk_pats(24'h654321), 1'b1, 3*7 + 3, 10);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (u_if.digits !== 24'd0) begin errors++; $display("FAIL mrst_digits got %h want 000000", u_if.digits); end
    if (u_if.frame_valid !== 1'b0) begin errors++; $display("FAIL mrst_fv got %b want 0", u_if.frame_valid); end
    if (u_if.decode_err !== 1'b0) begin errors++; $display("FAIL mrst_derr got %b want 0", u_if.decode_err); end
    if (u_if.seq_err !== 1'b0) begin errors++; $display("FAIL mrst_seq got %b want 0", u_if.seq_err); end
    if (u_if.locked !== 1'b0) begin errors++; $display("FAIL mrst_locked got %b want 0", u_if.locked); end
    rst = 1'b0;
    idle(6);
    hold_sym(3'd0, 3'd0, 1'b0, 1'b1, 3);
    idle(10);
    checks += 1;
    if (u_if.locked !== 1'b0) begin errors++; $display("FAIL short_hold_locked got %b want 0", u_if.locked); end
    sb_q.push_back({1'b0, 24'h000009});
    send_frame(mk_pats(24'h000009), 1'b1, 42, 10);
    idle(4);
    wait_drain();
    checks += 1;
    if (sb_q.size() != 0) begin errors++; $display("FAIL mrst_pending got %0d want 0", sb_q.size()); end
  endtask

  initial begin
    u_if.seg_bit   = 1'b0;
    u_if.seg_idx   = 3'd7;
    u_if.disp_idx  = 3'd7;
    u_if.disp_type = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic_low();
    test_back_to_back();
    test_blank();
    test_seq_jump();
    test_decode_err();
    test_glitch_recv();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
